// File: rtl/seq_mult32_wb.sv
// Iterative shift-add multiplier (unsigned or two's complement) that writes one
// 32-bit half of the 64-bit product back through a register-file write port.
module seq_mult32_wb #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SEL_W-1:0] dest,
   input  logic             hi_sel,
   input  logic             signed_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic [SEL_W-1:0] w_sel,
   output logic             w_en
);

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [WIDTH-1:0]   mcand_q, mcand_n;
   logic [WIDTH-1:0]   mplier_q, mplier_n;
   logic [2*WIDTH-1:0] acc_q, acc_n;
   logic               sign_q, sign_n;
   logic               hi_q, hi_n;
   logic [SEL_W-1:0]   dest_q, dest_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;
   logic               wen_q, wen_n;
   logic [WIDTH-1:0]   wdata_q, wdata_n;
   logic [SEL_W-1:0]   wsel_q, wsel_n;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] res;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign busy  = busy_q;
   assign done  = done_q;
   assign w_en  = wen_q;
   assign d     = wdata_q;
   assign w_sel = wsel_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         sign_q   <= 1'b0;
         hi_q     <= 1'b0;
         dest_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         wsel_q   <= '0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         mcand_q  <= mcand_n;
         mplier_q <= mplier_n;
         acc_q    <= acc_n;
         sign_q   <= sign_n;
         hi_q     <= hi_n;
         dest_q   <= dest_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         wen_q    <= wen_n;
         wdata_q  <= wdata_n;
         wsel_q   <= wsel_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      mcand_n  = mcand_q;
      mplier_n = mplier_q;
      acc_n    = acc_q;
      sign_n   = sign_q;
      hi_n     = hi_q;
      dest_n   = dest_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
      wen_n    = 1'b0;
      wdata_n  = wdata_q;
      wsel_n   = wsel_q;

      // Magnitudes: 0x80000000 negates to itself, which is the correct unsigned magnitude.
      a_mag = (signed_en && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag = (signed_en && b[WIDTH-1]) ? (~b + 1'b1) : b;
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      res   = sign_q ? (~acc_q + 1'b1) : acc_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_n  = a_mag;
               mplier_n = b_mag;
               sign_n   = signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
               hi_n     = hi_sel;
               dest_n   = dest;
               acc_n    = '0;
               cnt_n    = '0;
               busy_n   = 1'b1;
               state_n  = RUN;
            end
         end
         RUN: begin
            // Carry, accumulator and multiplier form one right-shifting chain.
            acc_n    = {sum, acc_q[WIDTH-1:1]};
            mplier_n = {acc_q[0], mplier_q[WIDTH-1:1]};
            cnt_n    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_n = WB;
         end
         WB: begin
            wdata_n = hi_q ? res[2*WIDTH-1:WIDTH] : res[WIDTH-1:0];
            wsel_n  = dest_q;
            wen_n   = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_mult32_wb.sv
// Directed bench for seq_mult32_wb: scoreboard of expected write-backs, a small
// register-file model on the write port, and timing checks around each operation.
module tb_seq_mult32_wb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  dest = '0;
   logic        hi_sel = 1'b0;
   logic        signed_en = 1'b0;
   logic        busy, done, w_en;
   logic [31:0] d;
   logic [4:0]  w_sel;

   int          checks = 0;
   int          errors = 0;
   logic [36:0] exp_q[$];
   logic [31:0] last_d = '0;
   logic [4:0]  last_sel = '0;

   logic [31:0] rf [32];
   logic        pl_en = 1'b0;
   logic [4:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always #5 clk = ~clk;

   seq_mult32_wb dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .dest(dest),
      .hi_sel(hi_sel), .signed_en(signed_en), .busy(busy), .done(done),
      .d(d), .w_sel(w_sel), .w_en(w_en)
   );

   always @(posedge clk) begin
      if (w_en) rf[w_sel] <= d;
      else if (pl_en) rf[pl_addr] <= pl_data;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // glitch != 0: pulse start with other operands so it is sampled at edge E<glitch>.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [4:0] idest,
                         input logic ihi, input logic isg, input int glitch);
      logic [63:0] p;
      logic [36:0] e;
      int          n;
      bit          seen;
      if (isg) p = $signed({{32{ia[31]}}, ia}) * $signed({{32{ib[31]}}, ib});
      else     p = {32'h0, ia} * {32'h0, ib};
      exp_q.push_back({idest, ihi ? p[63:32] : p[31:0]});
      a = ia; b = ib; dest = idest; hi_sel = ihi; signed_en = isg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_e0", 64'(busy), 64'd1);
      check("wen_e0", 64'(w_en), 64'd0);
      check("done_e0", 64'(done), 64'd0);
      check("d_hold", 64'(d), 64'(last_d));
      check("wsel_hold", 64'(w_sel), 64'(last_sel));
      a = $urandom; b = $urandom; dest = 5'($urandom_range(0, 31));
      hi_sel = 1'($urandom_range(0, 1)); signed_en = 1'($urandom_range(0, 1));
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         if (glitch != 0 && n == glitch - 1) begin
            start = 1'b1; a = 32'h1234; dest = 5'd3;
         end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (w_en) seen = 1'b1;
         else if (n == 16 || n == 32) check("busy_run", 64'(busy), 64'd1);
      end
      check("wb_latency", 64'(n), 64'd33);
      check("wb_wen", 64'(w_en), 64'd1);
      check("wb_done", 64'(done), 64'd1);
      check("wb_busy", 64'(busy), 64'd0);
      check("exp_q_size", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("wb_d", 64'(d), 64'(e[31:0]));
         check("wb_sel", 64'(w_sel), 64'(e[36:32]));
         last_d = e[31:0];
         last_sel = e[36:32];
      end
   endtask

   initial begin
      bit wen_seen;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wen", 64'(w_en), 64'd0);
      check("rst_d", 64'(d), 64'd0);
      check("rst_wsel", 64'(w_sel), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(32'd3, 32'd7, 5'd5, 1'b0, 1'b0, 0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b0, 1'b0, 0);
      run_op(32'hFFFFFFFE, 32'd3, 5'd4, 1'b0, 1'b1, 0);
      run_op(32'hFFFFFFFE, 32'd3, 5'd6, 1'b1, 1'b1, 0);
      run_op(32'h80000000, 32'h80000000, 5'd7, 1'b1, 1'b1, 0);
      run_op(32'h80000000, 32'd1, 5'd0, 1'b0, 1'b1, 0);
      run_op(32'd0, 32'h1234, 5'd10, 1'b0, 1'b1, 0);
      @(posedge clk); #1;

      // Op A with an ignored start mid-run, then op B sampled at E34.
      run_op(32'd2, 32'd5, 5'd9, 1'b0, 1'b0, 10);
      run_op(32'd4, 32'd4, 5'd2, 1'b0, 1'b0, 0);
      @(posedge clk); #1;

      // Reset asserted between E10 and E11 of an operation.
      a = 32'd9; b = 32'd9; dest = 5'd11; hi_sel = 1'b0; signed_en = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_wen", 64'(w_en), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_d", 64'(d), 64'd0);
      check("arst_wsel", 64'(w_sel), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      last_d = '0; last_sel = '0;
      wen_seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (w_en) wen_seen = 1'b1;
      end
      check("no_wb_after_reset", 64'(wen_seen), 64'd0);
      run_op(32'h1111, 32'h10, 5'd12, 1'b0, 1'b0, 0);

      for (int i = 0; i < 4; i++)
         run_op($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
      @(posedge clk); #1;

      // Register-file integration: r27 = r3 * r8 (low word).
      pl_en = 1'b1; pl_addr = 5'd3; pl_data = 32'h33333333;
      @(posedge clk); #1;
      pl_addr = 5'd8; pl_data = 32'h00000002;
      @(posedge clk); #1;
      pl_en = 1'b0;
      run_op(rf[3], rf[8], 5'd27, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      check("rf_r27", 64'(rf[27]), 64'h66666666);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
